// File: rtl/truth_table_sweep.sv
// rtl/truth_table_sweep.sv - drives all 8 minterms into a 3-input stage and grades its response
module truth_table_sweep #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'b0010_0100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       aa,
  output logic       bb,
  output logic       cc,
  input  logic       yy,
  output logic [2:0] mt,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] mt_q, mt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] table_q, table_d;
  logic       pass_q, pass_d;
  logic [3:0] fc_q, fc_d;
  logic [2:0] ff_q, ff_d;

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    table_d = table_q;
    pass_d  = pass_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    case (state_q)
      IDLE: begin
        mt_d  = 3'd0;
        cnt_d = 4'd0;
        if (start) begin
          state_d = SETTLE;
          table_d = 8'd0;
          fc_d    = 4'd0;
          ff_d    = 3'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[mt_q] = yy;
        if (yy != EXPECTED[mt_q]) begin
          fc_d = fc_q + 4'd1;
          // Only the first mismatch of the sweep records its minterm.
          if (fc_q == 4'd0) ff_d = mt_q;
        end
        if (mt_q == 3'd7) begin
          mt_d    = 3'd0;
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (table_d == EXPECTED);
        end else begin
          mt_d    = mt_q + 3'd1;
          cnt_d   = 4'd0;
          state_d = SETTLE;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mt_q    <= 3'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 8'd0;
      pass_q  <= 1'b0;
      fc_q    <= 4'd0;
      ff_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
    end
  end

  assign {aa, bb, cc} = mt_q;
  assign mt           = mt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign fail_count   = fc_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb/tb_truth_table_sweep.sv - randomized sweeps of two instances against a behavioural model
module tb_truth_table_sweep;

  localparam logic [7:0] EXP = 8'h24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_v, yy_v;
  int   sel;

  logic start0, yy0, aa0, bb0, cc0, busy0, done0, pass0;
  logic [2:0] mt0, ff0;
  logic [7:0] tbl0;
  logic [3:0] fc0;
  logic start1, yy1, aa1, bb1, cc1, busy1, done1, pass1;
  logic [2:0] mt1, ff1;
  logic [7:0] tbl1;
  logic [3:0] fc1;

  truth_table_sweep #(.SETTLE_CYCLES(2), .EXPECTED(EXP)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .aa(aa0), .bb(bb0), .cc(cc0), .yy(yy0),
    .mt(mt0), .busy(busy0), .done(done0), .table_out(tbl0), .pass(pass0),
    .fail_count(fc0), .first_fail(ff0)
  );

  truth_table_sweep #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .aa(aa1), .bb(bb1), .cc(cc1), .yy(yy1),
    .mt(mt1), .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1),
    .fail_count(fc1), .first_fail(ff1)
  );

  wire        s1 = (sel != 0);
  assign start0 = s1 ? 1'b0 : start_v;
  assign start1 = s1 ? start_v : 1'b0;
  assign yy0    = s1 ? 1'b0 : yy_v;
  assign yy1    = s1 ? yy_v : 1'b0;

  wire       o_aa   = s1 ? aa1 : aa0;
  wire       o_bb   = s1 ? bb1 : bb0;
  wire       o_cc   = s1 ? cc1 : cc0;
  wire [2:0] o_mt   = s1 ? mt1 : mt0;
  wire       o_busy = s1 ? busy1 : busy0;
  wire       o_done = s1 ? done1 : done0;
  wire [7:0] o_tbl  = s1 ? tbl1 : tbl0;
  wire       o_pass = s1 ? pass1 : pass0;
  wire [3:0] o_fc   = s1 ? fc1 : fc0;
  wire [2:0] o_ff   = s1 ? ff1 : ff0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] res_tbl;
  logic [3:0] res_fc;
  logic [2:0] res_ff;
  logic       res_pass;
  int         done_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int popc(input logic [7:0] x);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mt"}, o_mt, 0);
    chk({tag, "_abc"}, {o_aa, o_bb, o_cc}, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_table"}, o_tbl, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_fc"}, o_fc, 0);
    chk({tag, "_ff"}, o_ff, 0);
  endtask

  // The stage under test answers tbl[minterm] in SAMPLE cycles and noise otherwise.
  task automatic sweep(input logic [7:0] tbl, input bit hold);
    int s;
    int lat;
    int em;
    s   = s1 ? 1 : 2;
    lat = 8 * (s + 1) + 1;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("idle_mt", o_mt, 0);
    start_v = 1'b1;
    yy_v    = 1'($urandom);
    done_n  = 0;
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk); #1;
      if (o_done && done_n == 0) done_n = n;
      if (n == 1) begin
        chk("clr_table", o_tbl, 0);
        chk("clr_fc", o_fc, 0);
        chk("clr_ff", o_ff, 0);
        chk("clr_pass", o_pass, 0);
      end
      if (n < lat) begin
        em = (n - 1) / (s + 1);
        chk("run_mt", o_mt, em);
        chk("run_abc", {o_aa, o_bb, o_cc}, em);
        chk("run_busy", o_busy, 1);
        chk("run_done", o_done, 0);
      end else begin
        chk("end_mt", o_mt, 0);
        chk("end_busy", o_busy, 0);
        chk("end_done", o_done, 1);
        chk("end_table", o_tbl, tbl);
        chk("end_fc", o_fc, popc(tbl ^ EXP));
        chk("end_ff", o_ff, lowest(tbl ^ EXP));
        chk("end_pass", o_pass, (tbl == EXP));
      end
      @(negedge clk);
      if (!hold) start_v = 1'b0;
      yy_v = ((n - 1) % (s + 1) == s) ? tbl[{o_aa, o_bb, o_cc}] : 1'($urandom);
    end
    res_tbl  = o_tbl;
    res_fc   = o_fc;
    res_ff   = o_ff;
    res_pass = o_pass;
  endtask

  task automatic hold_check();
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_done", o_done, 0);
      chk("hold_busy", o_busy, 0);
      chk("hold_mt", o_mt, 0);
      chk("hold_table", o_tbl, res_tbl);
      chk("hold_fc", o_fc, res_fc);
      chk("hold_ff", o_ff, res_ff);
      chk("hold_pass", o_pass, res_pass);
    end
  endtask

  initial begin
    logic [7:0] t;
    logic [7:0] first_tbl;
    sel     = 0;
    reset   = 1'b1;
    start_v = 1'b0;
    yy_v    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    sweep(8'h24, 1'b0);
    chk("lit_ok_done_cycle", done_n, 25);
    chk("lit_ok_table", res_tbl, 8'h24);
    chk("lit_ok_pass", res_pass, 1);
    chk("lit_ok_fc", res_fc, 0);
    chk("lit_ok_ff", res_ff, 0);
    hold_check();

    sweep(8'h00, 1'b0);
    chk("lit_zero_table", res_tbl, 8'h00);
    chk("lit_zero_fc", res_fc, 2);
    chk("lit_zero_ff", res_ff, 2);
    chk("lit_zero_pass", res_pass, 0);
    hold_check();

    sweep(8'hDB, 1'b0);
    chk("lit_inv_table", res_tbl, 8'hDB);
    chk("lit_inv_fc", res_fc, 8);
    chk("lit_inv_ff", res_ff, 0);
    chk("lit_inv_pass", res_pass, 0);
    hold_check();

    for (int k = 0; k < 5; k++) begin
      t = 8'($urandom);
      sweep(t, 1'b0);
      hold_check();
    end

    // Start held high: the restart from IDLE must clear results and repeat identically.
    sweep(8'h24, 1'b1);
    first_tbl = res_tbl;
    sweep(8'h24, 1'b0);
    chk("held_same_table", res_tbl, first_tbl);
    chk("held_done_cycle", done_n, 25);
    hold_check();

    // Abort while mt=4 with an all-ones response so partial results are nonzero.
    @(negedge clk);
    start_v = 1'b1;
    yy_v    = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      chk("abort_run_done", o_done, 0);
    end
    chk("abort_mt_before", o_mt, 4);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("abort");
    @(negedge clk);
    reset   = 1'b0;
    start_v = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      chk("abort_no_done", o_done, 0);
      chk("abort_idle_busy", o_busy, 0);
    end
    sweep(8'h24, 1'b0);
    chk("abort_restart_cycle", done_n, 25);
    chk("abort_restart_pass", res_pass, 1);

    @(negedge clk);
    sel = 1;
    sweep(8'h24, 1'b0);
    chk("s1_done_cycle", done_n, 17);
    chk("s1_pass", res_pass, 1);
    hold_check();
    for (int k = 0; k < 3; k++) begin
      t = 8'($urandom);
      sweep(t, 1'b0);
      hold_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
